payment_controller: RTL and testbench

PAYMENT_CONTROLLER -- requirements
Module: payment_controller

---
 rtl/payment_controller.sv | 151 +++++++++++++++
 tb/tb_payment_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/payment_controller.sv
// Vending payment FSM: accepts an order, collects coins, dispenses, returns change or refund.
// Optional feature macro PAY_TIMEOUT_EN adds an idle-cycle auto-refund from PAY.
module payment_controller #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        order_valid,
    output logic        order_ready,
    input  logic [15:0] price,
    input  logic        stock_err,
    input  logic        coin_valid,
    input  logic [7:0]  coin_value,
    input  logic        cancel,
    output logic        dispense,
    output logic        change_valid,
    output logic [15:0] change_amt,
    output logic [15:0] paid_total,
    output logic        order_err,
    output logic        timeout,
    output logic [1:0]  state_dbg
);

    // Handshake: an order transfers on a cycle where order_valid && order_ready;
    // order_ready is high only in IDLE, so order_valid is ignored elsewhere.

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PAY      = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] price_r, price_nxt;
    logic [15:0] paid_nxt;
    logic [15:0] change_amt_nxt;
    logic        change_valid_nxt;
    logic        order_err_nxt;
    logic [16:0] coin_sum;
    logic        accept;

    assign order_ready = (state == S_IDLE);
    assign dispense    = (state == S_DISPENSE);
    assign state_dbg   = state;
    assign accept      = order_valid && order_ready;
    assign coin_sum    = {1'b0, paid_total} + {9'd0, coin_value};

`ifdef PAY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
    logic          tmo_hit;
    logic          timeout_nxt;

    // Counts consecutive coin-free PAY cycles; any coin or leaving PAY restarts it.
    always_comb begin
        tmo_cnt_nxt = '0;
        tmo_hit     = 1'b0;
        if (state == S_PAY && !coin_valid) begin
            tmo_cnt_nxt = tmo_cnt + 1'b1;
            tmo_hit     = (tmo_cnt_nxt == TW'(TIMEOUT_CYCLES));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            tmo_cnt <= tmo_cnt_nxt;
            timeout <= timeout_nxt;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt        = state;
        price_nxt        = price_r;
        paid_nxt         = paid_total;
        change_amt_nxt   = change_amt;
        change_valid_nxt = 1'b0;
        order_err_nxt    = 1'b0;
`ifdef PAY_TIMEOUT_EN
        timeout_nxt      = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (stock_err) begin
                        order_err_nxt = 1'b1;
                    end else begin
                        price_nxt = price;
                        state_nxt = (price == 16'd0) ? S_DISPENSE : S_PAY;
                    end
                end
            end
            S_PAY: begin
                if (coin_valid) begin
                    paid_nxt = coin_sum[16] ? 16'hFFFF : coin_sum[15:0];
                end
                // Cancel outranks completion, so a completing coin sent with cancel is refunded.
                if (cancel) begin
                    state_nxt        = S_CHANGE;
                    change_amt_nxt   = paid_nxt;
                    change_valid_nxt = (paid_nxt != 16'd0);
                end else if (paid_nxt >= price_r) begin
                    state_nxt = S_DISPENSE;
`ifdef PAY_TIMEOUT_EN
                end else if (tmo_hit) begin
                    state_nxt        = S_CHANGE;
                    change_amt_nxt   = paid_total;
                    change_valid_nxt = (paid_total != 16'd0);
                    timeout_nxt      = 1'b1;
`endif
                end
            end
            S_DISPENSE: begin
                state_nxt        = S_CHANGE;
                change_amt_nxt   = paid_total - price_r;
                change_valid_nxt = (paid_total != price_r);
            end
            S_CHANGE: begin
                paid_nxt  = 16'd0;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Change amount and pulse are registered on entry to CHANGE so both are valid in that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            price_r      <= 16'd0;
            paid_total   <= 16'd0;
            change_amt   <= 16'd0;
            change_valid <= 1'b0;
            order_err    <= 1'b0;
        end else begin
            state        <= state_nxt;
            price_r      <= price_nxt;
            paid_total   <= paid_nxt;
            change_amt   <= change_amt_nxt;
            change_valid <= change_valid_nxt;
            order_err    <= order_err_nxt;
        end
    end

endmodule

// File: tb/tb_payment_controller.sv
// Directed bench for payment_controller with hand-computed expectations.
// Timeout behaviour is exercised according to whether PAY_TIMEOUT_EN is defined.
module tb_payment_controller;

    logic        clk;
    logic        reset;
    logic        order_valid;
    logic        order_ready;
    logic [15:0] price;
    logic        stock_err;
    logic        coin_valid;
    logic [7:0]  coin_value;
    logic        cancel;
    logic        dispense;
    logic        change_valid;
    logic [15:0] change_amt;
    logic [15:0] paid_total;
    logic        order_err;
    logic        timeout;
    logic [1:0]  state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [1:0] ST_IDLE = 2'd0, ST_PAY = 2'd1, ST_DISP = 2'd2, ST_CHG = 2'd3;

    payment_controller #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .order_valid  (order_valid),
        .order_ready  (order_ready),
        .price        (price),
        .stock_err    (stock_err),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .cancel       (cancel),
        .dispense     (dispense),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .paid_total   (paid_total),
        .order_err    (order_err),
        .timeout      (timeout),
        .state_dbg    (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_order(input logic [15:0] p, input logic e);
        order_valid = 1'b1;
        price       = p;
        stock_err   = e;
        tick();
        order_valid = 1'b0;
        stock_err   = 1'b0;
    endtask

    task automatic put_coin(input logic [7:0] v, input logic c);
        coin_valid = 1'b1;
        coin_value = v;
        cancel     = c;
        tick();
        coin_valid = 1'b0;
        cancel     = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        order_valid = 1'b0;
        price       = 16'd0;
        stock_err   = 1'b0;
        coin_valid  = 1'b0;
        coin_value  = 8'd0;
        cancel      = 1'b0;
        #12;
        check("rst_state", state_dbg, ST_IDLE);
        check("rst_ready", order_ready, 1);
        check("rst_disp", dispense, 0);
        check("rst_cv", change_valid, 0);
        check("rst_amt", change_amt, 0);
        check("rst_paid", paid_total, 0);
        check("rst_oerr", order_err, 0);
        check("rst_tmo", timeout, 0);
        tick();
        reset = 1'b0;
        tick();

        // Coins outside PAY are ignored
        put_coin(8'd5, 1'b1);
        check("idle_coin_paid", paid_total, 0);
        check("idle_coin_state", state_dbg, ST_IDLE);

        // Price 45, coins 20,20,10 -> change 5
        put_order(16'd45, 1'b0);
        check("p45_state", state_dbg, ST_PAY);
        check("p45_ready", order_ready, 0);
        put_coin(8'd20, 1'b0);
        check("p45_paid1", paid_total, 20);
        put_coin(8'd20, 1'b0);
        check("p45_paid2", paid_total, 40);
        check("p45_nodisp", dispense, 0);
        put_coin(8'd10, 1'b0);
        check("p45_disp", dispense, 1);
        check("p45_paid3", paid_total, 50);
        tick();
        check("p45_disp_off", dispense, 0);
        check("p45_cv", change_valid, 1);
        check("p45_amt", change_amt, 5);
        tick();
        check("p45_idle", state_dbg, ST_IDLE);
        check("p45_paid0", paid_total, 0);
        check("p45_cv_off", change_valid, 0);
        check("p45_amt_hold", change_amt, 5);

        // Price 30, coins 10,20 -> exact; order_valid held during PAY must be ignored
        put_order(16'd30, 1'b0);
        order_valid = 1'b1;
        price       = 16'd5;
        put_coin(8'd10, 1'b0);
        check("p30_ignore_order", state_dbg, ST_PAY);
        order_valid = 1'b0;
        put_coin(8'd20, 1'b0);
        check("p30_disp", dispense, 1);
        tick();
        check("p30_state_chg", state_dbg, ST_CHG);
        check("p30_no_cv", change_valid, 0);
        tick();
        check("p30_idle", state_dbg, ST_IDLE);

        // Rejected order, then a free order
        put_order(16'd77, 1'b1);
        check("rej_oerr", order_err, 1);
        check("rej_state", state_dbg, ST_IDLE);
        check("rej_ready", order_ready, 1);
        tick();
        check("rej_oerr_off", order_err, 0);
        check("rej_nodisp", dispense, 0);
        put_order(16'd0, 1'b0);
        check("free_disp", dispense, 1);
        tick();
        check("free_no_cv", change_valid, 0);
        tick();
        check("free_idle", state_dbg, ST_IDLE);

        // Price 50, coin 20, cancel with coin 10 -> refund 30
        put_order(16'd50, 1'b0);
        put_coin(8'd20, 1'b0);
        put_coin(8'd10, 1'b1);
        check("cxl_state", state_dbg, ST_CHG);
        check("cxl_nodisp", dispense, 0);
        check("cxl_cv", change_valid, 1);
        check("cxl_amt", change_amt, 30);
        tick();
        check("cxl_idle", state_dbg, ST_IDLE);
        check("cxl_paid0", paid_total, 0);

        // Saturation: 256 x 255 = 0xFF00, +254 = 0xFFFE, +255 saturates to 0xFFFF
        put_order(16'hFFFF, 1'b0);
        for (int i = 0; i < 256; i++) put_coin(8'd255, 1'b0);
        check("sat_paid_ff00", paid_total, 16'hFF00);
        put_coin(8'd254, 1'b0);
        check("sat_paid_fffe", paid_total, 16'hFFFE);
        check("sat_nodisp", dispense, 0);
        put_coin(8'd255, 1'b0);
        check("sat_paid_ffff", paid_total, 16'hFFFF);
        check("sat_disp", dispense, 1);
        tick();
        check("sat_no_cv", change_valid, 0);
        tick();

`ifdef PAY_TIMEOUT_EN
        // Price 40, coin 10, then silence -> refund 10 on the eighth idle cycle
        put_order(16'd40, 1'b0);
        put_coin(8'd10, 1'b0);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("tmo_early", timeout, 0);
        end
        tick();
        check("tmo_pulse", timeout, 1);
        check("tmo_cv", change_valid, 1);
        check("tmo_amt", change_amt, 10);
        tick();
        check("tmo_off", timeout, 0);
        check("tmo_idle", state_dbg, ST_IDLE);
`else
        // Without the timeout feature PAY waits indefinitely
        put_order(16'd40, 1'b0);
        put_coin(8'd10, 1'b0);
        repeat (20) tick();
        check("notmo_state", state_dbg, ST_PAY);
        check("notmo_tmo", timeout, 0);
        put_coin(8'd0, 1'b1);
        check("notmo_cv", change_valid, 1);
        check("notmo_amt", change_amt, 10);
        tick();
`endif

        // Reset mid-PAY with 25 paid
        put_order(16'd60, 1'b0);
        put_coin(8'd25, 1'b0);
        check("mid_paid25", paid_total, 25);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_state", state_dbg, ST_IDLE);
        check("mid_rst_paid", paid_total, 0);
        check("mid_rst_ready", order_ready, 1);
        tick();
        reset = 1'b0;
        tick();
        check("mid_no_cv", change_valid, 0);
        check("mid_amt", change_amt, 0);
        check("mid_idle", state_dbg, ST_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
